serial_receiver: RTL and testbench



---
 rtl/serial_receiver.sv | 95 +++++++++
 tb/tb_serial_receiver.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/serial_receiver.sv
// Deserializer for the 7-bit single-wire frame: start 0, LSB-first data, parity, stop 1.
// Optional RX_SYNC_EN adds a 2-flop input synchronizer (+2 clocks latency).
//
// state | meaning
// IDLE  | line idle, waiting for a start bit (0)
// DATA  | shifting in payload plus parity bit
// STOP  | sampling stop bit, loading the output register
// BREAK | stop bit was 0; hold off until the line returns high
module serial_receiver #(
  parameter int DATA_BITS  = 7,
  parameter bit PARITY_ODD = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err
);

  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS);

  typedef enum logic [1:0] {IDLE, DATA, STOP, BREAK} state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [DATA_BITS:0]   shreg;
  logic                 sbit;
  logic                 par_xor;

`ifdef RX_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], serial_in};
  end

  assign sbit = sync_q[1];
`else
  assign sbit = serial_in;
`endif

  assign par_xor = ^shreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      shreg       <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!sbit) begin
            state <= DATA;
            cnt   <= '0;
          end
        end
        DATA: begin
          shreg <= {sbit, shreg[DATA_BITS:1]};
          cnt   <= cnt + CW'(1);
          if (cnt == LAST_BIT) state <= STOP;
        end
        STOP: begin
          state <= sbit ? IDLE : BREAK;
        end
        BREAK: begin
          if (sbit) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // A load always wins over a consume; overrun only when the old word was not taken.
      if (state == STOP) begin
        data_out    <= shreg[DATA_BITS-1:0];
        data_valid  <= 1'b1;
        parity_err  <= par_xor ^ PARITY_ODD;
        frame_err   <= ~sbit;
        overrun_err <= data_valid & ~data_ready;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_receiver.sv
// Directed bench for serial_receiver: frames driven bit by bit, words captured and checked in order.
module tb_serial_receiver;

`ifdef RX_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif
  localparam int LAT = 9 + SYNC_LAT;

  logic       clk = 1'b0;
  logic       rst;
  logic       serial_in;
  logic [6:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       parity_err;
  logic       frame_err;
  logic       overrun_err;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int valid_cycles = 0;
  int v0;

  typedef struct {
    logic [6:0] d;
    logic       pe;
    logic       fe;
    logic       oe;
    int         cyc;
  } rec_t;

  rec_t mon_q[$];
  int   starts[$];

  serial_receiver dut (
    .clk        (clk),
    .rst        (rst),
    .serial_in  (serial_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every word the consumer takes, stamped with the cycle it was visible.
  always @(negedge clk) begin
    rec_t r;
    if (data_valid) valid_cycles <= valid_cycles + 1;
    if (data_valid && data_ready) begin
      r.d   = data_out;
      r.pe  = parity_err;
      r.fe  = frame_err;
      r.oe  = overrun_err;
      r.cyc = cyc;
      mon_q.push_back(r);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    serial_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [6:0] d, input logic par, input logic stop);
    send_bit(1'b0);
    starts.push_back(cyc);
    for (int i = 0; i < 7; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stop);
  endtask

  task automatic check_word(input string tag, input logic [6:0] d, input logic pe,
                            input logic fe, input logic oe);
    rec_t r;
    int   st;
    chk({tag, "_present"}, 32'(mon_q.size() > 0), 32'd1);
    if (mon_q.size() > 0 && starts.size() > 0) begin
      r  = mon_q.pop_front();
      st = starts.pop_front();
      chk({tag, "_data"},    32'(r.d),  32'(d));
      chk({tag, "_parity"},  32'(r.pe), 32'(pe));
      chk({tag, "_frame"},   32'(r.fe), 32'(fe));
      chk({tag, "_overrun"}, 32'(r.oe), 32'(oe));
      chk({tag, "_latency"}, 32'(r.cyc - st), 32'(LAT));
    end
  endtask

  initial begin
    rst        = 1'b1;
    serial_in  = 1'b1;
    data_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data",  32'(data_out), 32'h0);
    chk("rst_valid", 32'(data_valid), 32'h0);
    chk("rst_flags", 32'({parity_err, frame_err, overrun_err}), 32'h0);
    rst = 1'b0;

    // idle line
    v0 = valid_cycles;
    repeat (20) send_bit(1'b1);
    chk("idle_valid", 32'(valid_cycles - v0), 32'd0);
    chk("idle_words", 32'(mon_q.size()), 32'd0);

    // single clean frame 0x41
    v0 = valid_cycles;
    send_frame(7'h41, 1'b1, 1'b1);
    repeat (6) send_bit(1'b1);
    check_word("f41", 7'h41, 1'b0, 1'b0, 1'b0);
    chk("f41_valid_cycles", 32'(valid_cycles - v0), 32'd1);

    // back-to-back 0x41, 0x2A
    send_frame(7'h41, 1'b1, 1'b1);
    send_frame(7'h2A, 1'b0, 1'b1);
    repeat (6) send_bit(1'b1);
    check_word("b2b_a", 7'h41, 1'b0, 1'b0, 1'b0);
    check_word("b2b_b", 7'h2A, 1'b0, 1'b0, 1'b0);
    chk("b2b_extra", 32'(mon_q.size()), 32'd0);

    // parity error
    send_frame(7'h41, 1'b0, 1'b1);
    repeat (6) send_bit(1'b1);
    check_word("perr", 7'h41, 1'b1, 1'b0, 1'b0);

    // frame error followed by a held-low line
    send_frame(7'h55, 1'b1, 1'b0);
    repeat (5) send_bit(1'b0);
    repeat (14) send_bit(1'b1);
    check_word("ferr", 7'h55, 1'b0, 1'b1, 1'b0);
    chk("ferr_spurious", 32'(mon_q.size()), 32'd0);

    // overrun with consumer stalled
    data_ready = 1'b0;
    send_frame(7'h11, 1'b1, 1'b1);
    repeat (6) send_bit(1'b1);
    chk("ovr1_valid",   32'(data_valid), 32'd1);
    chk("ovr1_data",    32'(data_out), 32'h11);
    chk("ovr1_overrun", 32'(overrun_err), 32'd0);
    send_frame(7'h22, 1'b1, 1'b1);
    repeat (6) send_bit(1'b1);
    chk("ovr2_valid",   32'(data_valid), 32'd1);
    chk("ovr2_data",    32'(data_out), 32'h22);
    chk("ovr2_overrun", 32'(overrun_err), 32'd1);
    chk("ovr2_flags",   32'({parity_err, frame_err}), 32'd0);
    data_ready = 1'b1;
    send_bit(1'b1);
    chk("ovr_consume", 32'(data_valid), 32'd0);
    mon_q.delete();
    starts.delete();

    // reset during data bit 4 of 0x7F
    send_bit(1'b0);
    repeat (4) send_bit(1'b1);
    serial_in = 1'b1;
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    repeat (14) send_bit(1'b1);
    chk("abort_words", 32'(mon_q.size()), 32'd0);
    chk("abort_valid", 32'(data_valid), 32'd0);
    send_frame(7'h03, 1'b1, 1'b1);
    repeat (6) send_bit(1'b1);
    check_word("post_rst", 7'h03, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
